// File: rtl/button_pkg.sv
// button_pkg
// Purpose: shared definitions for the button encoder: parameter defaults,
//          button index constants, the handshake FSM state encoding and the
//          priority encoder used when several presses land together.
// Ports:   none (package).
package button_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int CNT_W_DEFAULT           = 16;
  localparam int NUM_BUTTONS             = 4;

  localparam logic [1:0] BTN0 = 2'd0;
  localparam logic [1:0] BTN1 = 2'd1;
  localparam logic [1:0] BTN2 = 2'd2;
  localparam logic [1:0] BTN3 = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  // Highest index wins; lower simultaneous presses are simply not encoded.
  function automatic logic [1:0] encode_press(input logic [NUM_BUTTONS-1:0] ev);
    logic [1:0] code;
    if (ev[3])      code = BTN3;
    else if (ev[2]) code = BTN2;
    else if (ev[1]) code = BTN1;
    else            code = BTN0;
    return code;
  endfunction

endpackage

// File: rtl/Debouncer.sv
// Debouncer
// Purpose: one-button front end. Two-flop synchronizer followed by a
//          stability counter; the debounced level only follows the
//          synchronized input after it has differed for DEBOUNCE_CYCLES
//          consecutive cycles.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset
//   din    - raw asynchronous button level
//   level  - debounced level
module Debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             held_q,  held_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    if (sync2_q == held_q) begin
      // Agreement (including a bounce back) throws away partial progress.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      held_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = held_q;

endmodule

// File: rtl/button_encoder.sv
// button_encoder
// Purpose: debounces four buttons, turns rising edges of the debounced
//          levels into press events, and offers the encoded index of a press
//          on a valid/ready handshake. A press arriving while a code is
//          pending and not being consumed is dropped and flagged.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-high reset
//   buttonIn  - raw buttons, bit n is button n
//   codeOut   - encoded index of the accepted press
//   codeValid - codeOut holds an unconsumed press
//   codeReady - consumer takes codeOut when codeValid && codeReady
//   held      - debounced level of each button
//   overrun   - one-cycle pulse when a press is dropped
module button_encoder
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttonIn,
  output logic [1:0]             codeOut,
  output logic                   codeValid,
  input  logic                   codeReady,
  output logic [NUM_BUTTONS-1:0] held,
  output logic                   overrun
);

  logic [NUM_BUTTONS-1:0] held_w;
  logic [NUM_BUTTONS-1:0] prev_held_q, prev_held_d;
  logic [NUM_BUTTONS-1:0] press_ev;
  logic                   press_any;
  logic [1:0]             press_code;

  state_t     state_q, state_d;
  logic [1:0] code_q,  code_d;
  logic       overrun_q, overrun_d;

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_deb
    Debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .din  (buttonIn[gi]),
      .level(held_w[gi])
    );
  end

  // Rising edges only: releases never produce an event.
  assign press_ev   = held_w & ~prev_held_q;
  assign press_any  = |press_ev;
  assign press_code = encode_press(press_ev);

  always_comb begin
    prev_held_d = held_w;
    state_d     = state_q;
    code_d      = code_q;
    overrun_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_any) begin
          state_d = ST_VALID;
          code_d  = press_code;
        end
      end
      ST_VALID: begin
        if (codeReady) begin
          // Consumption and a new press on the same edge: reload without a bubble.
          if (press_any) code_d  = press_code;
          else           state_d = ST_IDLE;
        end else if (press_any) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_held_q <= '0;
      state_q     <= ST_IDLE;
      code_q      <= 2'b00;
      overrun_q   <= 1'b0;
    end else begin
      prev_held_q <= prev_held_d;
      state_q     <= state_d;
      code_q      <= code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign codeOut   = code_q;
  assign codeValid = (state_q == ST_VALID);
  assign held      = held_w;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_encoder.sv
// tb_button_encoder
// Purpose: directed self-checking bench for button_encoder with a short
//          debounce period. "Edge 0" in each scenario is the clock edge just
//          before the stimulus changes; raw inputs change 1 time unit after it.
// Ports:   none (top-level bench).
module tb_button_encoder;

  localparam int DEB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttonIn;
  logic [1:0] codeOut;
  logic       codeValid;
  logic       codeReady;
  logic [3:0] held;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  button_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .buttonIn (buttonIn),
    .codeOut  (codeOut),
    .codeValid(codeValid),
    .codeReady(codeReady),
    .held     (held),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Release everything and let any pending code be consumed.
  task automatic drain();
    buttonIn  = 4'b0000;
    codeReady = 1'b1;
    ticks(DEB + 6);
    codeReady = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    buttonIn  = 4'b0000;
    codeReady = 1'b0;
    ticks(2);
    checks++; if (codeOut !== 2'b00) begin errors++; $display("FAIL reset_codeOut got %b expected 00", codeOut); end
    checks++; if (codeValid !== 1'b0) begin errors++; $display("FAIL reset_codeValid got %b expected 0", codeValid); end
    checks++; if (held !== 4'b0000) begin errors++; $display("FAIL reset_held got %b expected 0000", held); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b expected 0", overrun); end
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_press();
    int bad;
    codeReady = 1'b0;
    buttonIn  = 4'b0100;
    for (int e = 1; e <= DEB + 3; e++) begin
      tick();
      if (e == DEB + 1) begin
        checks++; if (held !== 4'b0000) begin errors++; $display("FAIL single_held_early got %b expected 0000 at edge %0d", held, e); end
      end
      if (e == DEB + 2) begin
        checks++; if (held !== 4'b0100) begin errors++; $display("FAIL single_held got %b expected 0100 at edge %0d", held, e); end
        checks++; if (codeValid !== 1'b0) begin errors++; $display("FAIL single_valid_early got %b expected 0 at edge %0d", codeValid, e); end
      end
      if (e == DEB + 3) begin
        checks++; if (codeValid !== 1'b1) begin errors++; $display("FAIL single_valid got %b expected 1 at edge %0d", codeValid, e); end
        checks++; if (codeOut !== 2'b10) begin errors++; $display("FAIL single_code got %b expected 10", codeOut); end
      end
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (codeValid !== 1'b1 || codeOut !== 2'b10 || held !== 4'b0100) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_steady got %0d bad cycles expected 0", bad); end
    codeReady = 1'b1;
    tick();
    checks++; if (codeValid !== 1'b0) begin errors++; $display("FAIL single_consume got %b expected 0", codeValid); end
    drain();
    $display("test_single_press done");
  endtask

  task automatic test_bounce();
    int bad_held;
    int bad_valid;
    bad_held  = 0;
    bad_valid = 0;
    codeReady = 1'b0;
    buttonIn  = 4'b0000;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) buttonIn[1] = ~buttonIn[1];
      tick();
      if (held !== 4'b0000) bad_held++;
      if (codeValid !== 1'b0) bad_valid++;
    end
    buttonIn = 4'b0000;
    for (int c = 0; c < DEB + 4; c++) begin
      tick();
      if (held !== 4'b0000) bad_held++;
      if (codeValid !== 1'b0) bad_valid++;
    end
    checks++; if (bad_held !== 0) begin errors++; $display("FAIL bounce_held got %0d changed cycles expected 0", bad_held); end
    checks++; if (bad_valid !== 0) begin errors++; $display("FAIL bounce_valid got %0d valid cycles expected 0", bad_valid); end
    $display("test_bounce done");
  endtask

  task automatic test_simultaneous();
    int ov;
    ov        = 0;
    codeReady = 1'b0;
    buttonIn  = 4'b1011;
    for (int e = 1; e <= DEB + 6; e++) begin
      tick();
      if (overrun !== 1'b0) ov++;
      if (e == DEB + 2) begin
        checks++; if (held !== 4'b1011) begin errors++; $display("FAIL simul_held got %b expected 1011", held); end
      end
      if (e == DEB + 3) begin
        checks++; if (codeValid !== 1'b1) begin errors++; $display("FAIL simul_valid got %b expected 1", codeValid); end
        checks++; if (codeOut !== 2'b11) begin errors++; $display("FAIL simul_code got %b expected 11", codeOut); end
      end
    end
    checks++; if (ov !== 0) begin errors++; $display("FAIL simul_overrun got %0d pulses expected 0", ov); end
    drain();
    checks++; if (codeValid !== 1'b0) begin errors++; $display("FAIL simul_drain got %b expected 0", codeValid); end
    $display("test_simultaneous done");
  endtask

  task automatic test_overrun();
    codeReady = 1'b0;
    buttonIn  = 4'b0001;
    ticks(DEB + 3);
    checks++; if (codeValid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got %b expected 1", codeValid); end
    checks++; if (codeOut !== 2'b00) begin errors++; $display("FAIL ovr_first_code got %b expected 00", codeOut); end
    buttonIn = 4'b0101;
    for (int e = 1; e <= DEB + 4; e++) begin
      tick();
      if (e == DEB + 2) begin
        checks++; if (held !== 4'b0101) begin errors++; $display("FAIL ovr_held got %b expected 0101", held); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b expected 0", overrun); end
      end
      if (e == DEB + 3) begin
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b expected 1", overrun); end
        checks++; if (codeOut !== 2'b00) begin errors++; $display("FAIL ovr_code got %b expected 00", codeOut); end
        checks++; if (codeValid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b expected 1", codeValid); end
      end
      if (e == DEB + 4) begin
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pulse_end got %b expected 0", overrun); end
        checks++; if (codeOut !== 2'b00) begin errors++; $display("FAIL ovr_code_after got %b expected 00", codeOut); end
      end
    end
    codeReady = 1'b1;
    tick();
    checks++; if (codeValid !== 1'b0) begin errors++; $display("FAIL ovr_consume got %b expected 0", codeValid); end
    codeReady = 1'b0;
    drain();
    $display("test_overrun done");
  endtask

  task automatic test_back_to_back();
    int ov;
    ov        = 0;
    codeReady = 1'b1;
    buttonIn  = 4'b0010;
    tick();
    buttonIn  = 4'b1010;
    for (int e = 2; e <= DEB + 5; e++) begin
      tick();
      if (overrun !== 1'b0) ov++;
      if (e == DEB + 2) begin
        checks++; if (held !== 4'b0010) begin errors++; $display("FAIL b2b_held1 got %b expected 0010", held); end
      end
      if (e == DEB + 3) begin
        checks++; if (codeValid !== 1'b1 || codeOut !== 2'b01) begin errors++; $display("FAIL b2b_first got valid %b code %b expected valid 1 code 01", codeValid, codeOut); end
      end
      if (e == DEB + 4) begin
        checks++; if (codeValid !== 1'b1 || codeOut !== 2'b11) begin errors++; $display("FAIL b2b_second got valid %b code %b expected valid 1 code 11", codeValid, codeOut); end
      end
      if (e == DEB + 5) begin
        checks++; if (codeValid !== 1'b0 || codeOut !== 2'b11) begin errors++; $display("FAIL b2b_idle got valid %b code %b expected valid 0 code 11", codeValid, codeOut); end
      end
    end
    checks++; if (ov !== 0) begin errors++; $display("FAIL b2b_overrun got %0d pulses expected 0", ov); end
    drain();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    codeReady = 1'b0;
    buttonIn  = 4'b1000;
    ticks(DEB + 3);
    checks++; if (codeValid !== 1'b1 || codeOut !== 2'b11) begin errors++; $display("FAIL rmid_pending got valid %b code %b expected valid 1 code 11", codeValid, codeOut); end
    buttonIn = 4'b0001;
    ticks(5);
    #1 reset = 1'b1;
    #1;
    checks++; if (codeOut !== 2'b00) begin errors++; $display("FAIL rmid_code got %b expected 00", codeOut); end
    checks++; if (codeValid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b expected 0", codeValid); end
    checks++; if (held !== 4'b0000) begin errors++; $display("FAIL rmid_held got %b expected 0000", held); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun got %b expected 0", overrun); end
    tick();
    reset = 1'b0;
    for (int e = 1; e <= DEB + 3; e++) begin
      tick();
      if (e == DEB + 2) begin
        checks++; if (held !== 4'b0001) begin errors++; $display("FAIL rmid_held_after got %b expected 0001", held); end
        checks++; if (codeValid !== 1'b0) begin errors++; $display("FAIL rmid_valid_early got %b expected 0", codeValid); end
      end
      if (e == DEB + 3) begin
        checks++; if (codeValid !== 1'b1 || codeOut !== 2'b00) begin errors++; $display("FAIL rmid_press got valid %b code %b expected valid 1 code 00", codeValid, codeOut); end
      end
    end
    drain();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_encoder.md
BUTTON_ENCODER -- requirements
Module: button_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the consecutive cycles a synchronized input must hold a new level before it is accepted (legal range 2..65535).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the debounce counter width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock (rising edge).
REQ-004 The block SHALL have port reset, input, 1 bit, with asynchronous, active-high reset.
REQ-005 The block SHALL have port buttonIn, input, 4 bits, raw asynchronous active-high buttons; bit n is button n.
REQ-006 The block SHALL have port codeOut, output, 2 bits, the encoded index of the accepted button press.
REQ-007 The block SHALL have port codeValid, output, 1 bit; high means codeOut holds an unconsumed press.
REQ-008 The block SHALL have port codeReady, input, 1 bit; consumer accepts codeOut when codeValid && codeReady at a clk edge.
REQ-009 The block SHALL have port held, output, 4 bits, the debounced level of each button.
REQ-010 The block SHALL have port overrun, output, 1 bit, a one-cycle pulse when a press is dropped.

Function
REQ-011 Each buttonIn bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Per button: if sync level == held level, the counter SHALL clear to 0; otherwise it SHALL increment; when the counter equals DEBOUNCE_CYCLES-1 on an edge where the level still differs, held SHALL take the sync level and the counter SHALL clear.
REQ-013 A bounce back to the held level before the count completes SHALL clear the counter, with no change to held.
REQ-014 A press event SHALL be a 0->1 transition of a held bit (registered previous-held compare); releases SHALL generate no event.
REQ-015 Simultaneous press events SHALL encode the highest index (3 > 2 > 1 > 0); lower simultaneous presses SHALL be discarded without overrun.
REQ-016 The FSM SHALL have states IDLE and VALID; codeValid = (state == VALID).
REQ-017 IDLE + press event -> VALID, codeOut loaded with the encoded index on the same edge.
REQ-018 VALID + codeReady + no press event -> IDLE; codeOut retains its last value.
REQ-019 VALID + codeReady + press event on the same cycle -> stay VALID, codeOut loaded with the new index (back-to-back, no bubble).
REQ-020 VALID + !codeReady + press event -> event dropped, codeOut unchanged, overrun high for exactly the next cycle.
REQ-021 codeOut SHALL NOT change while codeValid is high and codeReady is low.
REQ-022 Latency: a raw level held stable from edge 0 SHALL update held at edge DEBOUNCE_CYCLES+2 and assert codeValid at edge DEBOUNCE_CYCLES+3.

Reset
REQ-023 Reset SHALL asynchronously force synchronizers, counters, held, previous-held, codeOut = 2'b00, codeValid = 0, overrun = 0, and FSM = IDLE.
REQ-024 Reset asserted mid-debounce or mid-handshake SHALL discard all progress; buttons already high at reset release SHALL generate a press only after a full debounce period.

Structure
REQ-025 Shared package button_pkg SHALL hold the FSM state encodings, the DEBOUNCE_CYCLES/CNT_W defaults, and the button index constants.
REQ-026 The synchronizer plus counter SHALL be sub-module Debouncer (one bit in, held level out), instantiated four times.

Verification (DEBOUNCE_CYCLES=8 in the bench)
REQ-027 buttonIn=0100 held from edge 0, codeReady=0 -> held[2]=1 at edge 10, codeValid=1 and codeOut=2'b10 at edge 11, held steady until codeReady.
REQ-028 buttonIn[1] toggles every 3 cycles for 40 cycles, then returns to 0 -> no held change, codeValid never asserts.
REQ-029 buttonIn=1011 asserted on the same cycle -> one event, codeOut=2'b11, overrun stays 0.
REQ-030 Button 0 press accepted with codeReady=0, then button 2 pressed -> overrun pulses one cycle, codeOut stays 2'b00; after codeReady, codeValid=0.
REQ-031 codeReady held at 1 while button 3 press event coincides with completion of the button-1 handshake -> codeValid stays 1, codeOut 2'b01 -> 2'b11.
REQ-032 Reset pulsed 5 cycles into debounce with buttonIn=0001 held -> all outputs 0 immediately; codeValid rises at edge DEBOUNCE_CYCLES+3 counted from reset release.
